// File: rtl/wdt_pkg.sv
// Shared state and cause encodings for the windowed watchdog.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLOSED  = 2'd1,
    OPEN    = 2'd2,
    EXPIRED = 2'd3
  } wdt_state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_EARLY   = 2'b10;

endpackage

// File: rtl/wdt_pulse_gen.sv
// Stretches a one-cycle trigger into a registered RST_PULSE-cycle pulse.
module wdt_pulse_gen #(
  parameter int RST_PULSE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_trigger,
  output logic o_pulse,
  output logic o_last
);

  localparam int PW = $clog2(RST_PULSE + 1);

  logic [PW-1:0] r_cnt;
  logic          r_pulse;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_trigger) begin
      r_cnt   <= PW'(RST_PULSE);
      r_pulse <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - PW'(1);
      r_pulse <= (r_cnt > PW'(1));
    end
  end

  assign o_pulse = r_pulse;
  // High during the final cycle of the pulse so the FSM can leave EXPIRED on time.
  assign o_last  = (r_cnt == PW'(1));

endmodule

// File: rtl/windowed_wdt.sv
// Windowed watchdog: closed/open kick window, early warning, stretched reset pulse.
module windowed_wdt
  import wdt_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 30,
  parameter int WINDOW    = 10,
  parameter int WARN_AT   = 4,
  parameter int RST_PULSE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             kick,
  output logic             wdt_reset,
  output logic             wdt_warn,
  output logic             win_open,
  output logic [1:0]       cause,
  output logic [7:0]       expiry_cnt,
  output logic [CNT_W-1:0] count
);

  if (!(WARN_AT > 0 && WARN_AT <= WINDOW && WINDOW < TIMEOUT &&
        (TIMEOUT >> CNT_W) == 0 && RST_PULSE >= 1)) begin : g_bad_params
    $error("windowed_wdt: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_WIN_P1  = CNT_W'(WINDOW + 1);
  localparam logic [CNT_W-1:0] C_WARN    = CNT_W'(WARN_AT);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  wdt_state_t       r_state;
  wdt_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_code;
  logic             w_expire;
  logic [7:0]       r_expiry_cnt;
  logic             r_win_open;
  logic             r_warn;
  logic             w_pulse;
  logic             w_pulse_last;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_expire     = 1'b0;
    w_cause_code = CAUSE_NONE;
    unique case (r_state)
      IDLE: begin
        w_count_nxt = C_TIMEOUT;
        if (enable) w_state_nxt = CLOSED;
      end
      CLOSED: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_count_nxt = C_TIMEOUT;
        end else if (kick) begin
          w_state_nxt  = EXPIRED;
          w_expire     = 1'b1;
          w_cause_code = CAUSE_EARLY;
        end else begin
          if (r_count != '0) w_count_nxt = r_count - C_ONE;
          if (r_count == C_WIN_P1) w_state_nxt = OPEN;
        end
      end
      OPEN: begin
        // Disable outranks a simultaneous legal kick.
        if (!enable) begin
          w_state_nxt = IDLE;
          w_count_nxt = C_TIMEOUT;
        end else if (kick) begin
          w_state_nxt = CLOSED;
          w_count_nxt = C_TIMEOUT;
        end else if (r_count == '0) begin
          w_state_nxt  = EXPIRED;
          w_expire     = 1'b1;
          w_cause_code = CAUSE_TIMEOUT;
        end else begin
          w_count_nxt = r_count - C_ONE;
        end
      end
      EXPIRED: begin
        if (w_pulse_last) begin
          w_count_nxt = C_TIMEOUT;
          w_state_nxt = enable ? CLOSED : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= C_TIMEOUT;
      r_cause      <= CAUSE_NONE;
      r_expiry_cnt <= '0;
      r_win_open   <= 1'b0;
      r_warn       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_win_open <= (w_state_nxt == OPEN);
      r_warn     <= (w_state_nxt == OPEN) && (w_count_nxt <= C_WARN);
      if (w_expire) begin
        r_cause <= w_cause_code;
        if (r_expiry_cnt != 8'hFF) r_expiry_cnt <= r_expiry_cnt + 8'd1;
      end
    end
  end

  wdt_pulse_gen #(
    .RST_PULSE (RST_PULSE)
  ) u_pulse (
    .clock     (clock),
    .reset     (reset),
    .i_trigger (w_expire),
    .o_pulse   (w_pulse),
    .o_last    (w_pulse_last)
  );

  assign wdt_reset  = w_pulse;
  assign wdt_warn   = r_warn;
  assign win_open   = r_win_open;
  assign cause      = r_cause;
  assign expiry_cnt = r_expiry_cnt;
  assign count      = r_count;

endmodule

// File: tb/tb_windowed_wdt.sv
// Directed bench for windowed_wdt at default parameters.
module tb_windowed_wdt;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        kick;
  logic        wdt_reset;
  logic        wdt_warn;
  logic        win_open;
  logic [1:0]  cause;
  logic [7:0]  expiry_cnt;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  windowed_wdt dut (
    .clock      (clk),
    .reset      (reset),
    .enable     (enable),
    .kick       (kick),
    .wdt_reset  (wdt_reset),
    .wdt_warn   (wdt_warn),
    .win_open   (win_open),
    .cause      (cause),
    .expiry_cnt (expiry_cnt),
    .count      (count)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; kick = 1'b0;
    tick(2);
    chk("rst_count",  32'(count), 32'd30);
    chk("rst_wdtrst", 32'(wdt_reset), 32'd0);
    chk("rst_warn",   32'(wdt_warn), 32'd0);
    chk("rst_win",    32'(win_open), 32'd0);
    chk("rst_cause",  32'(cause), 32'd0);
    chk("rst_expcnt", 32'(expiry_cnt), 32'd0);

    // Free-run expiry
    reset = 1'b0; enable = 1'b1;
    tick(1);
    chk("load_count", 32'(count), 32'd30);
    tick(19);
    chk("l19_count", 32'(count), 32'd11);
    chk("l19_win",   32'(win_open), 32'd0);
    tick(1);
    chk("l20_count", 32'(count), 32'd10);
    chk("l20_win",   32'(win_open), 32'd1);
    tick(5);
    chk("l25_warn", 32'(wdt_warn), 32'd0);
    tick(1);
    chk("l26_count", 32'(count), 32'd4);
    chk("l26_warn",  32'(wdt_warn), 32'd1);
    tick(4);
    chk("l30_count",  32'(count), 32'd0);
    chk("l30_wdtrst", 32'(wdt_reset), 32'd0);
    tick(1);
    chk("l31_wdtrst", 32'(wdt_reset), 32'd1);
    chk("l31_cause",  32'(cause), 32'd1);
    chk("l31_expcnt", 32'(expiry_cnt), 32'd1);
    chk("l31_warn",   32'(wdt_warn), 32'd0);
    tick(3);
    chk("l34_wdtrst", 32'(wdt_reset), 32'd1);
    tick(1);
    chk("l35_wdtrst", 32'(wdt_reset), 32'd0);
    chk("l35_count",  32'(count), 32'd30);
    chk("l35_win",    32'(win_open), 32'd0);

    // Legal kick at count 5
    tick(25);
    chk("k5_pre_count", 32'(count), 32'd5);
    kick = 1'b1; tick(1); kick = 1'b0;
    chk("k5_count",  32'(count), 32'd30);
    chk("k5_wdtrst", 32'(wdt_reset), 32'd0);
    chk("k5_warn",   32'(wdt_warn), 32'd0);
    chk("k5_cause",  32'(cause), 32'd1);

    // Legal kick while warning is active
    tick(26);
    chk("k4_pre_warn", 32'(wdt_warn), 32'd1);
    kick = 1'b1; tick(1); kick = 1'b0;
    chk("k4_count", 32'(count), 32'd30);
    chk("k4_warn",  32'(wdt_warn), 32'd0);

    // Kick at zero
    tick(30);
    chk("k0_pre_count", 32'(count), 32'd0);
    kick = 1'b1; tick(1); kick = 1'b0;
    chk("k0_count",  32'(count), 32'd30);
    chk("k0_wdtrst", 32'(wdt_reset), 32'd0);
    tick(1);
    chk("k0_next_count",  32'(count), 32'd29);
    chk("k0_next_wdtrst", 32'(wdt_reset), 32'd0);
    chk("k0_expcnt",      32'(expiry_cnt), 32'd1);

    // Kick on the cycle the window opens
    tick(19);
    chk("kw_pre_win", 32'(win_open), 32'd1);
    kick = 1'b1; tick(1); kick = 1'b0;
    chk("kw_count",  32'(count), 32'd30);
    chk("kw_wdtrst", 32'(wdt_reset), 32'd0);

    // Early kick at count 15
    tick(15);
    chk("ke_pre_count", 32'(count), 32'd15);
    kick = 1'b1; tick(1); kick = 1'b0;
    chk("ke_wdtrst1", 32'(wdt_reset), 32'd1);
    chk("ke_cause",   32'(cause), 32'd2);
    chk("ke_expcnt",  32'(expiry_cnt), 32'd2);
    tick(3);
    chk("ke_wdtrst4", 32'(wdt_reset), 32'd1);
    tick(1);
    chk("ke_wdtrst5", 32'(wdt_reset), 32'd0);
    chk("ke_count",   32'(count), 32'd30);

    // Disable during OPEN
    tick(22);
    chk("dis_pre_win", 32'(win_open), 32'd1);
    enable = 1'b0; tick(1);
    chk("dis_count", 32'(count), 32'd30);
    chk("dis_win",   32'(win_open), 32'd0);
    tick(3);
    chk("dis_hold_count", 32'(count), 32'd30);
    chk("dis_cause",      32'(cause), 32'd2);
    chk("dis_expcnt",     32'(expiry_cnt), 32'd2);

    // Disable together with a legal kick
    enable = 1'b1; tick(1);
    tick(20);
    chk("dk_pre_win", 32'(win_open), 32'd1);
    kick = 1'b1; enable = 1'b0; tick(1); kick = 1'b0;
    chk("dk_count", 32'(count), 32'd30);
    tick(2);
    chk("dk_idle_count", 32'(count), 32'd30);

    // Enable dropped during EXPIRED is ignored until the pulse ends
    enable = 1'b1; tick(1);
    tick(31);
    chk("xe_wdtrst1", 32'(wdt_reset), 32'd1);
    chk("xe_cause",   32'(cause), 32'd1);
    chk("xe_expcnt",  32'(expiry_cnt), 32'd3);
    enable = 1'b0; tick(3);
    chk("xe_wdtrst4", 32'(wdt_reset), 32'd1);
    tick(1);
    chk("xe_wdtrst5", 32'(wdt_reset), 32'd0);
    chk("xe_count",   32'(count), 32'd30);
    tick(2);
    chk("xe_idle_count", 32'(count), 32'd30);

    // Reset mid-pulse
    enable = 1'b1; tick(1);
    tick(31);
    chk("rm_wdtrst1", 32'(wdt_reset), 32'd1);
    chk("rm_expcnt",  32'(expiry_cnt), 32'd4);
    tick(1);
    chk("rm_wdtrst2", 32'(wdt_reset), 32'd1);
    reset = 1'b1; tick(1);
    chk("rm_wdtrst", 32'(wdt_reset), 32'd0);
    chk("rm_cause",  32'(cause), 32'd0);
    chk("rm_expcnt", 32'(expiry_cnt), 32'd0);
    chk("rm_count",  32'(count), 32'd30);
    reset = 1'b0; enable = 1'b0; tick(2);
    chk("rm_idle_count",  32'(count), 32'd30);
    chk("rm_idle_wdtrst", 32'(wdt_reset), 32'd0);

    // Expiry counter saturation via repeated early kicks
    enable = 1'b1; tick(1);
    for (int i = 0; i < 260; i++) begin
      kick = 1'b1; tick(1); kick = 1'b0;
      chk("sat_wdtrst", 32'(wdt_reset), 32'd1);
      chk("sat_expcnt", 32'(expiry_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      tick(4);
    end
    chk("sat_final_expcnt", 32'(expiry_cnt), 32'd255);
    chk("sat_final_cause",  32'(cause), 32'd2);
    chk("sat_final_count",  32'(count), 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/windowed_wdt.md
# windowed_wdt

Parametrised windowed watchdog timer that supervises a periodic `kick` from system logic. It has these features:
- Programmable timeout.
- A closed window that rejects premature kicks.
- An early-warning output ahead of expiry.
- A stretched `wdt_reset` pulse.
- A cause code and a saturating expiry counter.

It sits between the system controller and the top-level reset generator. It replaces the fixed-period, single-mode watchdog.

## Interface
Parameters:
- `CNT_W`, 16: counter width.
- `TIMEOUT`, 30: reload value, in clock cycles.
- `WINDOW`, 10: kicks are legal only while `count <= WINDOW`.
- `WARN_AT`, 4: `wdt_warn` asserts while `count <= WARN_AT`.
- `RST_PULSE`, 4: `wdt_reset` width, in cycles.
- Legal values: `0 < WARN_AT <= WINDOW < TIMEOUT < 2**CNT_W` and `RST_PULSE >= 1`. Illegal values are rejected at elaboration.

Ports:
- `clock` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: arms the watchdog.
- `kick` in 1: service request, sampled each cycle.
- `wdt_reset` out 1: registered expiry pulse.
- `wdt_warn` out 1: registered pre-timeout warning.
- `win_open` out 1: high while a kick is legal.
- `cause` out 2: `00` none, `01` timeout, `10` early kick. Held until the next expiry or reset.
- `expiry_cnt` out 8: saturating count of expiries.
- `count` out CNT_W: current counter value, for debug.

## Operation
States are `IDLE`, `CLOSED`, `OPEN` and `EXPIRED`.

**Reset.** While `reset` is high the block is forced to:
- state `IDLE`, `count = TIMEOUT`;
- `cause = 00`, `expiry_cnt = 0`;
- `wdt_reset`, `wdt_warn` and `win_open` all low.

**IDLE.** The counter holds at `TIMEOUT`. When `enable=1`, the next state is `CLOSED`.

**CLOSED** (`count > WINDOW`):
- `count` decrements by 1 each cycle.
- When `count` reaches `WINDOW`, the state becomes `OPEN`.
- `kick=1` here is a violation: next state `EXPIRED`, `cause = 10`.

**OPEN** (`count <= WINDOW`):
- `win_open=1`.
- `kick=1` gives: `count = TIMEOUT`, state `CLOSED`, `wdt_warn` cleared.
- With no kick, `count` decrements.
- When `count == 0` and there is no kick, the next state is `EXPIRED` and `cause = 01`.

**EXPIRED:**
- `wdt_reset=1` for exactly `RST_PULSE` cycles.
- `kick` and `enable` are ignored.
- On entry, `expiry_cnt` increments, saturating at 255.
- After the pulse, `count = TIMEOUT` and the state becomes `CLOSED`, or `IDLE` if `enable=0`.

**Disabling.** `enable=0` in `CLOSED` or `OPEN` gives next state `IDLE` with `count = TIMEOUT`. `cause` and `expiry_cnt` are kept.

**Arithmetic.** `count` never underflows. Decrement happens only when `count > 0`.

## Timing
- All outputs are registered and change one cycle after the causing event.
- **Load.** `enable` is sampled high in `IDLE` at cycle N. At cycle N+1 the state is `CLOSED` with `count = TIMEOUT`.
- **Window open.** `win_open` rises on the cycle `count` first equals `WINDOW`, i.e. `TIMEOUT - WINDOW` cycles after load.
- **Warning.** `wdt_warn` is high on every cycle with `count <= WARN_AT` in `OPEN`.
- **Expiry latency.** If `count == 0` at cycle M with no kick, `wdt_reset` is high for cycles M+1 through M+`RST_PULSE`.
- **Reload.** A legal kick at cycle K gives `count = TIMEOUT` at K+1.

Simultaneous events:
- A kick at `count == 0` in `OPEN` reloads; there is no expiry.
- A kick on the same cycle the window opens is legal.
- `enable` falling together with a legal kick: `enable` wins and the state goes to `IDLE`.

Reset mid-pulse:
- `wdt_reset` drops the next cycle.
- The block returns to full reset values.

## Structure
Package `wdt_pkg` holds:
- the state enum `wdt_state_t`;
- the cause encoding constants `CAUSE_NONE`, `CAUSE_TIMEOUT`, `CAUSE_EARLY`.

Sub-module `wdt_pulse_gen` generates the `RST_PULSE`-wide output from a one-cycle trigger, with a `$clog2(RST_PULSE+1)`-bit down-counter. The top level contains the FSM, the main counter and the status registers.

## Test plan
All scenarios use the parameter defaults (`TIMEOUT=30`, `WINDOW=10`, `WARN_AT=4`, `RST_PULSE=4`).
1. **Free-run expiry.** `enable=1` from reset, never kick. Required: `win_open` at load+20, `wdt_warn` at load+26, `wdt_reset` high for load+31..34, `cause=01`, `expiry_cnt=1`, then `count=30` again.
2. **Legal kick.** Kick once when `count=5`. Required: `count=30` next cycle, no `wdt_reset`, `wdt_warn` low.
3. **Early kick.** Kick when `count=15`. Required: `wdt_reset` high for the next 4 cycles, `cause=10`.
4. **Kick at zero.** Kick at `count=0`. Required: reload to 30, no expiry.
5. **Reset mid-pulse.** Assert `reset` on the 2nd cycle of the `wdt_reset` pulse. Required: `wdt_reset=0`, `cause=00`, `expiry_cnt=0`, state `IDLE` next cycle.
6. **Expiry counter saturation.** Force 260 expiries. Required: `expiry_cnt` stays at 255. Also drop `enable` during `OPEN`: `IDLE` next cycle with `count=30`.
